// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe referee: cell codes, FSM states and win lines.
package ttt_pkg;

   localparam int unsigned NUM_CELLS = 9;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   typedef enum logic [1:0] {
      StTurn,
      StEval,
      StWin,
      StDraw
   } state_e;

   // Rows, columns, then the two diagonals, as row-major cell indices.
   localparam int unsigned WIN_LINES [8][3] = '{
      '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
      '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
      '{0, 4, 8}, '{2, 4, 6}
   };

   // Board code for a player number (0 = P1, 1 = P2).
   function automatic logic [1:0] player_code(input logic p);
      return p ? CELL_P2 : CELL_P1;
   endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-line detector for a single player code.
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [2*NUM_CELLS-1:0] board,
   input  logic [1:0]             player,
   output logic                   line_hit
);

   logic [7:0] w_hits;

   for (genvar g = 0; g < 8; g++) begin : g_line
      assign w_hits[g] = (board[2*WIN_LINES[g][0] +: 2] == player) &&
                         (board[2*WIN_LINES[g][1] +: 2] == player) &&
                         (board[2*WIN_LINES[g][2] +: 2] == player);
   end

   assign line_hit = |w_hits;

endmodule

// File: rtl/ttt_referee.sv
// Move-side referee: keeps the board, alternates turns, rejects illegal moves and
// reports win/draw. Optional build macro TTT_SCORE_EN adds saturating per-player
// win counters (score1/score2) that survive restart.
module ttt_referee
   import ttt_pkg::*;
#(
   parameter int unsigned INVALID_HOLD = 4,
   parameter bit          FIRST_PLAYER = 1'b0
) (
   input  logic        clk_out,
   input  logic        reset,
   input  logic        restart,
   input  logic        move_valid,
   input  logic [3:0]  move_cell,
   output logic        invalid,
   output logic        win1,
   output logic        win2,
   output logic        draw,
   output logic        turn,
`ifdef TTT_SCORE_EN
   output logic [3:0]  score1,
   output logic [3:0]  score2,
`endif
   output logic [17:0] board
);

   localparam logic [3:0] HOLD_LOAD = 4'(INVALID_HOLD);

   state_e      r_state, w_state_next;
   logic [17:0] r_board, w_board_next;
   logic [3:0]  r_move_count, w_move_count_next;
   logic [3:0]  r_hold, w_hold_next;
   logic        r_turn, w_turn_next;
   logic        r_win1, w_win1_next;
   logic        r_win2, w_win2_next;
   logic        r_draw, w_draw_next;
`ifdef TTT_SCORE_EN
   logic [3:0]  r_score1, w_score1_next;
   logic [3:0]  r_score2, w_score2_next;
`endif

   logic [1:0]           w_code;
   logic [NUM_CELLS-1:0] w_sel;
   logic [NUM_CELLS-1:0] w_occ;
   logic [17:0]          w_wr_board;
   logic                 w_reject;
   logic                 w_line_hit;

   assign w_code = player_code(r_turn);

   // Per-cell decode of the selected cell, its occupancy and the board with the move applied.
   for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
      assign w_sel[i] = (move_cell == 4'(i));
      assign w_occ[i] = (r_board[2*i+1:2*i] != CELL_EMPTY);
      assign w_wr_board[2*i+1:2*i] = w_sel[i] ? w_code : r_board[2*i+1:2*i];
   end

   assign w_reject = (move_cell > 4'd8) || (|(w_sel & w_occ));

   // During EVAL the board already holds the move of the player in r_turn.
   ttt_line_check u_line_check (
      .board    (r_board),
      .player   (w_code),
      .line_hit (w_line_hit)
   );

   // Next-state and datapath updates; restart overrides everything else.
   always_comb begin
      w_state_next      = r_state;
      w_board_next      = r_board;
      w_move_count_next = r_move_count;
      w_turn_next       = r_turn;
      w_win1_next       = r_win1;
      w_win2_next       = r_win2;
      w_draw_next       = r_draw;
      w_hold_next       = (r_hold != 4'd0) ? r_hold - 4'd1 : 4'd0;
`ifdef TTT_SCORE_EN
      w_score1_next     = r_score1;
      w_score2_next     = r_score2;
`endif
      if (!restart) begin
         w_state_next      = StTurn;
         w_board_next      = '0;
         w_move_count_next = 4'd0;
         w_turn_next       = FIRST_PLAYER;
         w_win1_next       = 1'b0;
         w_win2_next       = 1'b0;
         w_draw_next       = 1'b0;
         w_hold_next       = 4'd0;
      end else begin
         unique case (r_state)
            StTurn: begin
               if (move_valid) begin
                  if (w_reject) begin
                     w_hold_next = HOLD_LOAD;
                  end else begin
                     w_board_next      = w_wr_board;
                     w_move_count_next = r_move_count + 4'd1;
                     w_state_next      = StEval;
                  end
               end
            end
            StEval: begin
               if (w_line_hit) begin
                  w_state_next = StWin;
                  if (r_turn) begin
                     w_win2_next = 1'b1;
`ifdef TTT_SCORE_EN
                     if (r_score2 != 4'hF) w_score2_next = r_score2 + 4'd1;
`endif
                  end else begin
                     w_win1_next = 1'b1;
`ifdef TTT_SCORE_EN
                     if (r_score1 != 4'hF) w_score1_next = r_score1 + 4'd1;
`endif
                  end
               end else if (r_move_count == 4'd9) begin
                  w_state_next = StDraw;
                  w_draw_next  = 1'b1;
               end else begin
                  w_turn_next  = ~r_turn;
                  w_state_next = StTurn;
               end
            end
            StWin, StDraw: begin
            end
            default: begin
               w_state_next = StTurn;
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_out or negedge reset) begin
      if (!reset) begin
         r_state      <= StTurn;
         r_board      <= '0;
         r_move_count <= 4'd0;
         r_hold       <= 4'd0;
         r_turn       <= FIRST_PLAYER;
         r_win1       <= 1'b0;
         r_win2       <= 1'b0;
         r_draw       <= 1'b0;
`ifdef TTT_SCORE_EN
         r_score1     <= 4'd0;
         r_score2     <= 4'd0;
`endif
      end else begin
         r_state      <= w_state_next;
         r_board      <= w_board_next;
         r_move_count <= w_move_count_next;
         r_hold       <= w_hold_next;
         r_turn       <= w_turn_next;
         r_win1       <= w_win1_next;
         r_win2       <= w_win2_next;
         r_draw       <= w_draw_next;
`ifdef TTT_SCORE_EN
         r_score1     <= w_score1_next;
         r_score2     <= w_score2_next;
`endif
      end
   end

   assign invalid = (r_hold != 4'd0);
   assign win1    = r_win1;
   assign win2    = r_win2;
   assign draw    = r_draw;
   assign turn    = r_turn;
   assign board   = r_board;
`ifdef TTT_SCORE_EN
   assign score1  = r_score1;
   assign score2  = r_score2;
`endif

endmodule

// File: tb/tb_ttt_referee.sv
// Directed self-checking bench for ttt_referee (default parameters).
module tb_ttt_referee;

   logic        clk_out = 1'b0;
   logic        reset;
   logic        restart;
   logic        move_valid;
   logic [3:0]  move_cell;
   logic        invalid;
   logic        win1;
   logic        win2;
   logic        draw;
   logic        turn;
   logic [17:0] board;
`ifdef TTT_SCORE_EN
   logic [3:0]  score1;
   logic [3:0]  score2;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [17:0] exp_board;
   int          n_high;

   ttt_referee dut (
      .clk_out    (clk_out),
      .reset      (reset),
      .restart    (restart),
      .move_valid (move_valid),
      .move_cell  (move_cell),
      .invalid    (invalid),
      .win1       (win1),
      .win2       (win2),
      .draw       (draw),
      .turn       (turn),
`ifdef TTT_SCORE_EN
      .score1     (score1),
      .score2     (score2),
`endif
      .board      (board)
   );

   always #5 clk_out = ~clk_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk_out);
      @(negedge clk_out);
   endtask

   task automatic do_move(input logic [3:0] c);
      move_valid = 1'b1;
      move_cell  = c;
      tick();
      move_valid = 1'b0;
   endtask

   // Accepted move by player p2 (0 = P1, 1 = P2), then the EVAL cycle.
   task automatic play(input logic [3:0] c, input logic p2);
      int idx;
      idx = int'(c);
      do_move(c);
      exp_board[2*idx +: 2] = p2 ? 2'b10 : 2'b01;
      check("board_after_move", 32'(board), 32'(exp_board));
      tick();
   endtask

   task automatic do_restart();
      restart = 1'b0;
      tick();
      restart = 1'b1;
      exp_board = '0;
   endtask

   task automatic count_invalid(output int n);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (invalid) n++;
         tick();
      end
   endtask

   initial begin
      reset      = 1'b0;
      restart    = 1'b1;
      move_valid = 1'b0;
      move_cell  = 4'd0;
      exp_board  = '0;
      repeat (2) @(negedge clk_out);
      check("reset_board", 32'(board), 32'h0);
      check("reset_invalid", 32'(invalid), 32'h0);
      check("reset_win1", 32'(win1), 32'h0);
      check("reset_win2", 32'(win2), 32'h0);
      check("reset_draw", 32'(draw), 32'h0);
      check("reset_turn", 32'(turn), 32'h0);
      reset = 1'b1;
      tick();

      // Diagonal win for P1: 4, 0, 2, 1, 6
      play(4'd4, 1'b0);
      check("turn_after_p1", 32'(turn), 32'h1);
      play(4'd0, 1'b1);
      check("turn_after_p2", 32'(turn), 32'h0);
      play(4'd2, 1'b0);
      play(4'd1, 1'b1);
      do_move(4'd6);
      exp_board[13:12] = 2'b01;
      check("diag_board", 32'(board), 32'(exp_board));
      check("diag_win1_latency", 32'(win1), 32'h0);
      tick();
      check("diag_win1", 32'(win1), 32'h1);
      check("diag_win2", 32'(win2), 32'h0);
      check("diag_draw", 32'(draw), 32'h0);
      check("diag_turn_hold", 32'(turn), 32'h0);
      do_move(4'd3);
      tick();
      check("win_ignore_board", 32'(board), 32'(exp_board));
      check("win_ignore_invalid", 32'(invalid), 32'h0);
      check("win_ignore_win1", 32'(win1), 32'h1);
      check("win_ignore_turn", 32'(turn), 32'h0);
      do_restart();
      check("restart_board", 32'(board), 32'h0);
      check("restart_win1", 32'(win1), 32'h0);
      check("restart_turn", 32'(turn), 32'h0);

      // Occupied cell
      play(4'd4, 1'b0);
      do_move(4'd4);
      check("occ_invalid", 32'(invalid), 32'h1);
      count_invalid(n_high);
      check("occ_hold_len", 32'(n_high), 32'd4);
      check("occ_board", 32'(board), 32'(exp_board));
      check("occ_turn", 32'(turn), 32'h1);
      play(4'd5, 1'b1);
      check("occ_retry_turn", 32'(turn), 32'h0);
      // An accepted move right after a rejection leaves the hold running
      do_move(4'd5);
      play(4'd6, 1'b0);
      check("hold_not_cut", 32'(invalid), 32'h1);
      check("hold_turn", 32'(turn), 32'h1);
      repeat (3) tick();
      check("hold_expired", 32'(invalid), 32'h0);
      do_restart();

      // Out of range, with reload on the second rejection
      do_move(4'd9);
      check("oor9_invalid", 32'(invalid), 32'h1);
      tick();
      tick();
      do_move(4'd15);
      count_invalid(n_high);
      check("oor_reload_len", 32'(n_high), 32'd4);
      check("oor_board", 32'(board), 32'h0);
      check("oor_turn", 32'(turn), 32'h0);

      // Draw: 0 1 2 4 3 5 7 6 8
      play(4'd0, 1'b0); play(4'd1, 1'b1); play(4'd2, 1'b0);
      play(4'd4, 1'b1); play(4'd3, 1'b0); play(4'd5, 1'b1);
      play(4'd7, 1'b0); play(4'd6, 1'b1); play(4'd8, 1'b0);
      check("draw_flag", 32'(draw), 32'h1);
      check("draw_win1", 32'(win1), 32'h0);
      check("draw_win2", 32'(win2), 32'h0);
      check("draw_count", 32'(dut.r_move_count), 32'd9);
      do_move(4'd0);
      tick();
      check("draw_ignore_invalid", 32'(invalid), 32'h0);
      check("draw_ignore_board", 32'(board), 32'(exp_board));
      check("draw_hold", 32'(draw), 32'h1);
      do_restart();
      check("restart_draw", 32'(draw), 32'h0);

      // Ninth move completes column 0,3,6
      play(4'd0, 1'b0); play(4'd1, 1'b1); play(4'd2, 1'b0);
      play(4'd4, 1'b1); play(4'd3, 1'b0); play(4'd5, 1'b1);
      play(4'd7, 1'b0); play(4'd8, 1'b1); play(4'd6, 1'b0);
      check("ninth_win1", 32'(win1), 32'h1);
      check("ninth_draw", 32'(draw), 32'h0);
      check("ninth_win2", 32'(win2), 32'h0);
      do_restart();

      // P2 wins on row 3,4,5
      play(4'd0, 1'b0); play(4'd3, 1'b1); play(4'd1, 1'b0);
      play(4'd4, 1'b1); play(4'd8, 1'b0); play(4'd5, 1'b1);
      check("p2_win2", 32'(win2), 32'h1);
      check("p2_win1", 32'(win1), 32'h0);
      check("p2_turn", 32'(turn), 32'h1);
      do_restart();

      // Restart on the same edge as a legal move, with invalid active
      play(4'd0, 1'b0);
      play(4'd4, 1'b1);
      do_move(4'd9);
      restart    = 1'b0;
      move_valid = 1'b1;
      move_cell  = 4'd8;
      tick();
      restart    = 1'b1;
      move_valid = 1'b0;
      exp_board  = '0;
      check("rst_move_board", 32'(board), 32'h0);
      check("rst_move_turn", 32'(turn), 32'h0);
      check("rst_move_invalid", 32'(invalid), 32'h0);
      check("rst_move_flags", 32'({win1, win2, draw}), 32'h0);
      tick();
      check("rst_move_board_later", 32'(board), 32'h0);

      // Asynchronous reset while in EVAL
      play(4'd2, 1'b0);
      do_move(4'd7);
      #2 reset = 1'b0;
      #1;
      check("async_board", 32'(board), 32'h0);
      check("async_turn", 32'(turn), 32'h0);
      check("async_flags", 32'({win1, win2, draw, invalid}), 32'h0);
      @(negedge clk_out);
      reset     = 1'b1;
      exp_board = '0;
      tick();
      play(4'd4, 1'b0);
      check("after_async_turn", 32'(turn), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
